goertzel_bin_sched: RTL and testbench

Time-multiplexed scheduler for the MFCC front end's Goertzel spectral stage. It accepts framed audio samples and, for each sample, sequences one shared bin-update ALU across all NUM_BINS frequency bins, keeping per-bin state (s1, s2) in internal registers. At end of frame it streams one power value per bin over a valid/ready port, then clears the bin state. It sits between the framing/windowing stage and the mel filterbank, and addresses an external synchronous coefficient ROM.

---
 rtl/goertzel_pkg.sv | 32 +++
 rtl/goertzel_bin_alu.sv | 40 ++++
 rtl/goertzel_bin_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_goertzel_bin_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared widths, FSM state encoding and power saturation for the Goertzel bin scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package goertzel_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int COEF_W        = 16;
  localparam int STATE_W       = 32;
  localparam int POWER_W       = 32;
  localparam int ACC_W         = 64;
  localparam int COEF_FRAC_DEF = 14;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_UPD,
    ST_PADDR,
    ST_POUT,
    ST_CLR
  } state_t;

  // Clamp a shifted 64-bit signed power into the unsigned 32-bit output range.
  function automatic logic [POWER_W-1:0] sat_power(input logic signed [ACC_W-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > 64'sd4294967295) begin
      return '1;
    end else begin
      return v[POWER_W-1:0];
    end
  endfunction

endpackage

// File: rtl/goertzel_bin_alu.sv
// Shared Goertzel bin arithmetic: next state s = x + coef*s1 - s2 and saturated bin power.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the scheduler decides when results are consumed.
module goertzel_bin_alu
  import goertzel_pkg::*;
#(
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int PWR_SHIFT = 16
) (
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [COEF_W-1:0]   coef,
  input  logic signed [STATE_W-1:0]  s1,
  input  logic signed [STATE_W-1:0]  s2,
  output logic signed [STATE_W-1:0]  s_next,
  output logic [POWER_W-1:0]         power
);

  logic signed [ACC_W-1:0]   coef_w;
  logic signed [ACC_W-1:0]   s1_w;
  logic signed [ACC_W-1:0]   s2_w;
  logic signed [ACC_W-1:0]   p_w;
  logic signed [ACC_W-1:0]   pwr_raw;
  logic signed [ACC_W-1:0]   pwr_sh;
  logic signed [STATE_W-1:0] x_w;

  // Widen operands, form the scaled feedback term, then the state update and power.
  always_comb begin
    coef_w  = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
    s1_w    = {{(ACC_W-STATE_W){s1[STATE_W-1]}}, s1};
    s2_w    = {{(ACC_W-STATE_W){s2[STATE_W-1]}}, s2};
    x_w     = {{(STATE_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
    p_w     = (coef_w * s1_w) >>> COEF_FRAC;
    // State recursion wraps at 32 bits; only the low word of p contributes.
    s_next  = x_w + p_w[STATE_W-1:0] - s2;
    pwr_raw = (s1_w * s1_w) + (s2_w * s2_w) - (p_w * s2_w);
    pwr_sh  = pwr_raw >>> PWR_SHIFT;
    power   = sat_power(pwr_sh);
  end

endmodule

// File: rtl/goertzel_bin_sched.sv
// Goertzel scheduler: one shared ALU swept over all bins per sample, bin powers streamed at frame end.
// Latency: sample accepted at T, next sample accepted at T+NUM_BINS+2; first bin_valid 2 cycles after PADDR.
// Backpressure: sample_ready low outside WAIT; bin outputs and coef_addr hold while bin_ready is low.
module goertzel_bin_sched
  import goertzel_pkg::*;
#(
  parameter int NUM_BINS  = 32,
  parameter int FRAME_LEN = 256,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int PWR_SHIFT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        flush,
  input  logic signed [SAMPLE_W-1:0]  sample_in,
  input  logic                        sample_valid,
  input  logic                        sample_last,
  output logic                        sample_ready,
  output logic [$clog2(NUM_BINS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic [POWER_W-1:0]          bin_power,
  output logic [$clog2(NUM_BINS)-1:0] bin_idx,
  output logic                        bin_last,
  output logic                        bin_valid,
  input  logic                        bin_ready,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int UPD_W = $clog2(NUM_BINS + 1);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [UPD_W-1:0] UPD_END  = UPD_W'(NUM_BINS);
  localparam logic [UPD_W-1:0] ADDR_END = UPD_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t state;
  state_t state_nxt;

  logic                       started;
  logic [CNT_W-1:0]           smp_cnt;
  logic [UPD_W-1:0]           upd_cnt;
  logic [BIN_W-1:0]           out_k;
  logic                       frame_end;
  logic signed [SAMPLE_W-1:0] x_q;

  logic signed [STATE_W-1:0]  s1_arr [NUM_BINS];
  logic signed [STATE_W-1:0]  s2_arr [NUM_BINS];

  logic [BIN_W-1:0]           alu_sel;
  logic signed [STATE_W-1:0]  alu_s;
  logic [POWER_W-1:0]         alu_pwr;

  logic smp_acc;
  logic upd_we;
  logic pwr_cap;
  logic bin_hs;
  logic cnt_hit;
  logic smp_end;
  logic smp_err;

  // A frame ends on sample_last or on the FRAME_LEN-th sample; exactly one of the two is an error.
  assign cnt_hit = (smp_cnt == LAST_CNT);
  assign smp_end = sample_last | cnt_hit;
  assign smp_err = sample_last ^ cnt_hit;

  // During UPD the ALU works on the bin whose coefficient is arriving (one behind the address).
  assign alu_sel = (state == ST_UPD) ? BIN_W'(upd_cnt - 1'b1) : out_k;

  goertzel_bin_alu #(
    .COEF_FRAC (COEF_FRAC),
    .PWR_SHIFT (PWR_SHIFT)
  ) u_alu (
    .x      (x_q),
    .coef   (coef_data),
    .s1     (s1_arr[alu_sel]),
    .s2     (s2_arr[alu_sel]),
    .s_next (alu_s),
    .power  (alu_pwr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle action strobes; flush overrides every transition.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    busy         = (state != ST_WAIT);
    smp_acc      = 1'b0;
    upd_we       = 1'b0;
    pwr_cap      = 1'b0;
    bin_hs       = 1'b0;
    case (state)
      ST_WAIT: begin
        sample_ready = started && !((smp_cnt == '0) && !enable);
        if (sample_ready && sample_valid) begin
          smp_acc   = 1'b1;
          state_nxt = ST_UPD;
        end
      end
      ST_UPD: begin
        upd_we = (upd_cnt != '0);
        if (upd_cnt == UPD_END) begin
          state_nxt = frame_end ? ST_PADDR : ST_WAIT;
        end
      end
      ST_PADDR: begin
        state_nxt = ST_POUT;
      end
      ST_POUT: begin
        if (!bin_valid) begin
          pwr_cap = 1'b1;
        end else if (bin_ready) begin
          bin_hs    = 1'b1;
          state_nxt = (out_k == LAST_BIN) ? ST_CLR : ST_PADDR;
        end
      end
      ST_CLR: begin
        state_nxt = ST_WAIT;
      end
      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
    if (flush) begin
      state_nxt = ST_CLR;
      smp_acc   = 1'b0;
      upd_we    = 1'b0;
      pwr_cap   = 1'b0;
      bin_hs    = 1'b0;
    end
  end

  // Counters, ROM address, output registers and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      smp_cnt    <= '0;
      upd_cnt    <= '0;
      frame_end  <= 1'b0;
      x_q        <= '0;
      coef_addr  <= '0;
      out_k      <= '0;
      bin_valid  <= 1'b0;
      bin_last   <= 1'b0;
      bin_idx    <= '0;
      bin_power  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      started    <= 1'b1;
      frame_done <= bin_hs && (out_k == LAST_BIN);
      frame_err  <= smp_acc && smp_err;
      if (smp_acc) begin
        x_q       <= sample_in;
        smp_cnt   <= smp_cnt + 1'b1;
        frame_end <= smp_end;
        upd_cnt   <= '0;
        coef_addr <= '0;
      end
      if ((state == ST_UPD) && !flush) begin
        upd_cnt <= upd_cnt + 1'b1;
        // Stop at the last bin address instead of wrapping past it.
        if (upd_cnt < ADDR_END) begin
          coef_addr <= coef_addr + 1'b1;
        end
      end
      if ((state == ST_UPD) && (state_nxt == ST_PADDR)) begin
        coef_addr <= '0;
        out_k     <= '0;
      end
      if (pwr_cap) begin
        bin_power <= alu_pwr;
        bin_idx   <= out_k;
        bin_last  <= (out_k == LAST_BIN);
        bin_valid <= 1'b1;
      end
      if (bin_hs) begin
        bin_valid <= 1'b0;
        bin_last  <= 1'b0;
        if (out_k != LAST_BIN) begin
          out_k     <= out_k + 1'b1;
          coef_addr <= out_k + 1'b1;
        end
      end
      if (flush) begin
        bin_valid <= 1'b0;
        bin_last  <= 1'b0;
      end
      if (state == ST_CLR) begin
        smp_cnt   <= '0;
        out_k     <= '0;
        frame_end <= 1'b0;
      end
    end
  end

  // Per-bin Goertzel state: shifted on each bin update, wiped in CLR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        s1_arr[i] <= '0;
        s2_arr[i] <= '0;
      end
    end else if (state == ST_CLR) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        s1_arr[i] <= '0;
        s2_arr[i] <= '0;
      end
    end else if (upd_we) begin
      s1_arr[alu_sel] <= alu_s;
      s2_arr[alu_sel] <= s1_arr[alu_sel];
    end
  end

endmodule

// File: tb/tb_goertzel_bin_sched.sv
// Directed bench for goertzel_bin_sched with NUM_BINS=4, FRAME_LEN=8, PWR_SHIFT=0.
// Expected powers were worked out by hand from the Goertzel recursion for each stimulus.
// A small synchronous ROM model answers coef_addr one cycle later.
module tb_goertzel_bin_sched;

  localparam int NB = 4;
  localparam int FL = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               flush;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               sample_last;
  logic               sample_ready;
  logic [1:0]         coef_addr;
  logic signed [15:0] coef_data = '0;
  logic [31:0]        bin_power;
  logic [1:0]         bin_idx;
  logic               bin_last;
  logic               bin_valid;
  logic               bin_ready;
  logic               frame_done;
  logic               frame_err;
  logic               busy;

  logic signed [15:0] rom [NB];
  logic [31:0]        exp_pwr [NB];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  goertzel_bin_sched #(
    .NUM_BINS  (NB),
    .FRAME_LEN (FL),
    .COEF_FRAC (14),
    .PWR_SHIFT (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_last  (sample_last),
    .sample_ready (sample_ready),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .bin_power    (bin_power),
    .bin_idx      (bin_idx),
    .bin_last     (bin_last),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) coef_data <= rom[coef_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] x, input logic last);
    int g;
    g = 0;
    sample_valid = 1'b1;
    sample_in    = x;
    sample_last  = last;
    while (!sample_ready && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) check("send_timeout", 1, 0);
    step();
    sample_valid = 1'b0;
    sample_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic use_last,
                            input logic signed [15:0] first, input logic signed [15:0] rest);
    for (int i = 0; i < n; i++) begin
      send((i == 0) ? first : rest, use_last && (i == n - 1));
    end
  endtask

  task automatic set_exp(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    exp_pwr[0] = e0;
    exp_pwr[1] = e1;
    exp_pwr[2] = e2;
    exp_pwr[3] = e3;
  endtask

  // Drain one frame of bins, optionally stalling bin_ready for 5 cycles on one bin.
  task automatic collect(input string tag, input int stall_k);
    int          got;
    int          g;
    int          fd;
    logic [31:0] p0;
    logic [1:0]  i0;
    logic [1:0]  a0;
    logic [31:0] gp [NB];
    logic [1:0]  gi [NB];
    logic        gl [NB];
    got = 0;
    g = 0;
    fd = 0;
    bin_ready = 1'b1;
    while (got < NB && g < 300) begin
      if (frame_done) fd++;
      if (bin_valid && stall_k >= 0 && int'(bin_idx) == stall_k) begin
        bin_ready = 1'b0;
        p0 = bin_power;
        i0 = bin_idx;
        a0 = coef_addr;
        for (int s = 0; s < 5; s++) begin
          step();
          check({tag, "_stall_vld"},  bin_valid, 1);
          check({tag, "_stall_pwr"},  bin_power, p0);
          check({tag, "_stall_idx"},  bin_idx, i0);
          check({tag, "_stall_addr"}, coef_addr, a0);
        end
        bin_ready = 1'b1;
        stall_k = -1;
      end
      if (bin_valid) begin
        gp[got] = bin_power;
        gi[got] = bin_idx;
        gl[got] = bin_last;
        got++;
      end
      step();
      g++;
    end
    check({tag, "_nbins"}, got, NB);
    check({tag, "_early_done"}, fd, 0);
    for (int i = 0; i < got; i++) begin
      check({tag, "_pwr"},  gp[i], exp_pwr[i]);
      check({tag, "_idx"},  gi[i], i);
      check({tag, "_last"}, gl[i], (i == NB - 1) ? 1 : 0);
    end
    check({tag, "_done"}, frame_done, 1);
    step();
    check({tag, "_done_pulse"}, frame_done, 0);
    check({tag, "_ready_after"}, sample_ready, 1);
  endtask

  task automatic set_rom_default();
    rom[0] = 16'sd0;
    rom[1] = 16'sd16384;
    rom[2] = -16'sd16384;
    rom[3] = 16'sd32767;
  endtask

  initial begin
    int hs_cyc [FL];
    int g;

    set_rom_default();
    set_exp(32'd0, 32'd0, 32'd0, 32'd0);
    rst_n        = 1'b0;
    enable       = 1'b1;
    flush        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    bin_ready    = 1'b1;

    // Reset values while rst_n is held low.
    #22;
    check("rst_sample_ready", sample_ready, 0);
    check("rst_bin_valid",    bin_valid, 0);
    check("rst_bin_last",     bin_last, 0);
    check("rst_frame_done",   frame_done, 0);
    check("rst_frame_err",    frame_err, 0);
    check("rst_busy",         busy, 0);
    check("rst_coef_addr",    coef_addr, 0);
    check("rst_bin_idx",      bin_idx, 0);
    check("rst_bin_power",    bin_power, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", sample_ready, 1);
    enable = 1'b0;
    #1;
    check("enable_low_gates", sample_ready, 0);
    enable = 1'b1;
    #1;
    check("enable_high", sample_ready, 1);

    // Impulse frame: 1000 followed by seven zeros, last on the 8th.
    set_exp(32'd1000000, 32'd1000000, 32'd1000000, 32'd993028);
    send_frame(FL, 1'b1, 16'sd1000, 16'sd0);
    check("imp_no_err", frame_err, 0);
    collect("imp", -1);

    // Throughput with sample_valid held high, then backpressure on bin 2.
    sample_valid = 1'b1;
    for (int i = 0; i < FL; i++) begin
      sample_in   = (i == 0) ? 16'sd1000 : 16'sd0;
      sample_last = (i == FL - 1);
      g = 0;
      while (!sample_ready && g < 50) begin
        step();
        g++;
      end
      if (g >= 50) check("tput_timeout", 1, 0);
      hs_cyc[i] = cyc;
      if (i == 0) begin
        for (int j = 0; j < NB; j++) begin
          step();
          check("tput_addr_sweep", coef_addr, j);
        end
      end else begin
        step();
      end
    end
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    for (int i = 1; i < FL; i++) begin
      check("tput_spacing", hs_cyc[i] - hs_cyc[i-1], NB + 2);
    end
    collect("bp", 2);

    // Short frame: sample_last on the 5th sample.
    set_exp(32'd1000000, 32'd1000000, 32'd1000000, 32'd996010);
    send_frame(5, 1'b1, 16'sd1000, 16'sd0);
    check("short_err", frame_err, 1);
    step();
    check("short_err_pulse", frame_err, 0);
    collect("short", -1);

    // Full-length frame without sample_last; must also start from zero state.
    set_exp(32'd1000000, 32'd1000000, 32'd1000000, 32'd993028);
    send_frame(FL, 1'b0, 16'sd1000, 16'sd0);
    check("nolast_err", frame_err, 1);
    collect("nolast", -1);

    // Saturation: near-DC resonator driven by full-scale DC.
    for (int i = 0; i < NB; i++) rom[i] = 16'sd32767;
    set_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send_frame(FL, 1'b1, 16'sd32767, 16'sd32767);
    collect("sat", -1);
    set_rom_default();

    // Flush while bin 1 is being offered.
    send_frame(FL, 1'b1, 16'sd1000, 16'sd0);
    bin_ready = 1'b1;
    g = 0;
    while (!(bin_valid && bin_idx == 2'd1) && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) check("flush_timeout", 1, 0);
    bin_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_vld_drop", bin_valid, 0);
    check("flush_busy_clr", busy, 1);
    check("flush_no_done", frame_done, 0);
    step();
    check("flush_no_done2", frame_done, 0);
    check("flush_ready", sample_ready, 1);
    bin_ready = 1'b1;
    set_exp(32'd1000000, 32'd1000000, 32'd1000000, 32'd993028);
    send_frame(FL, 1'b1, 16'sd1000, 16'sd0);
    collect("post_flush", -1);

    // Asynchronous reset in the middle of a bin sweep.
    send(16'sd1000, 1'b0);
    step();
    step();
    check("upd_addr_mid", coef_addr, 2);
    check("upd_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_coef_addr", coef_addr, 0);
    check("arst_ready", sample_ready, 0);
    check("arst_bin_valid", bin_valid, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("arst_ready_back", sample_ready, 1);
    send_frame(FL, 1'b1, 16'sd1000, 16'sd0);
    collect("post_rst", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
